// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, with stall hold and redirect squash.
// Optional FETCH_PERF_EN adds fetch_cnt/squash_cnt performance counters.
module fetch_unit #(
    parameter int IMEM_DEPTH = 256,
    parameter int RESET_PC   = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] squash_cnt
`endif
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);
    logic [AW-1:0] pc, pc_d;
    logic          vld, held;
    logic [31:0]   held_inst;
    logic          unused_bits;
    assign unused_bits = ^target[31:AW];
    assign imem_addr = {{(32-AW){1'b0}}, pc};
    assign if_pc     = {{(32-AW){1'b0}}, pc_d};
    assign if_valid  = vld;
    assign if_inst   = vld ? (held ? held_inst : imem_inst) : 32'h0;
    // The memory keeps reading pc during a stall, so the word for pc_d is captured on the first stall edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RST_PC;
            pc_d      <= '0;
            vld       <= 1'b0;
            held      <= 1'b0;
            held_inst <= '0;
        end else if (redirect) begin
            pc   <= target[AW-1:0];
            pc_d <= pc;
            vld  <= 1'b0;
            held <= 1'b0;
        end else if (stall) begin
            held <= 1'b1;
            if (!held) held_inst <= imem_inst;
        end else begin
            pc   <= pc + 1'b1;
            pc_d <= pc;
            vld  <= 1'b1;
            held <= 1'b0;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (!redirect && !stall) fetch_cnt <= fetch_cnt + 1'b1;
            if (redirect && (vld || !stall)) squash_cnt <= squash_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a PC-level reference model.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] imem_addr, imem_inst, if_inst, if_pc;
    logic        if_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, squash_cnt;
`endif
    logic [31:0] mem [256];
    int errors = 0, checks = 0;
    int exp_pc = 0, exp_out = 0;
    bit exp_v = 0;
    int exp_fc = 0, exp_sc = 0;

    fetch_unit #(.IMEM_DEPTH(256), .RESET_PC(0)) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .target(target), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) imem_inst <= mem[imem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, 32'(exp_pc));
        chk("if_valid", {31'b0, if_valid}, {31'b0, exp_v});
        chk("if_pc", if_pc, 32'(exp_out));
        chk("if_inst", if_inst, exp_v ? mem[exp_out] : 32'h0);
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, 32'(exp_fc));
        chk("squash_cnt", squash_cnt, 32'(exp_sc));
`endif
    endtask

    task automatic model_reset();
        exp_pc = 0; exp_out = 0; exp_v = 0; exp_fc = 0; exp_sc = 0;
    endtask

    // One clock: apply inputs, advance the reference model at the edge, then compare.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s; redirect = r; target = t;
        @(posedge clock);
        if (r) begin
            if (exp_v || !s) exp_sc++;
            exp_out = exp_pc; exp_v = 0; exp_pc = int'(t % 256);
        end else if (!s) begin
            exp_out = exp_pc; exp_v = 1; exp_pc = (exp_pc + 1) % 256; exp_fc++;
        end
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 100);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_all();
        repeat (3) step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'd20);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 32'd9);
        step(0, 0, 0);
        step(0, 1, 32'd254);
        repeat (5) step(0, 0, 0);
        step(0, 1, 32'd300);
        step(0, 0, 0);
        step(1, 1, 32'd7);
        step(1, 0, 0);
        step(0, 1, 32'd50);
        step(0, 1, 32'd60);
        step(0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
